// File: rtl/argo_chan_pkg.sv
// ============================================================================
// Module   : argo_chan_pkg
// Purpose  : Definitions shared by the Argo channel endpoints (receive and,
//            later, send): FSM state encodings, the legal read-latency range
//            and the debug-trace format constants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package argo_chan_pkg;

    // Channel endpoint FSM state encodings
    typedef logic [1:0] chan_state_t;

    localparam logic [1:0] CHAN_IDLE  = 2'd0;
    localparam logic [1:0] CHAN_BLOCK = 2'd1;
    localparam logic [1:0] CHAN_FETCH = 2'd2;
    localparam logic [1:0] CHAN_DONE  = 2'd3;

    // FIFO RAM read latency is legal from 0 to RD_LATENCY_MAX cycles
    localparam int RD_LATENCY_MIN = 0;
    localparam int RD_LATENCY_MAX = 3;
    // Width of a counter able to hold any legal read latency
    localparam int LAT_CNT_W      = $clog2(RD_LATENCY_MAX + 1);

    // Debug-trace format constants
    localparam string TRACE_TAG_RECV  = "argo_chan_recv";
    localparam string TRACE_EV_ACCEPT = "accept";
    localparam string TRACE_EV_BLOCK  = "block";
    localparam string TRACE_EV_WAKE   = "wake";
    localparam string TRACE_EV_CANCEL = "cancel";
    localparam string TRACE_EV_DONE   = "done";

endpackage : argo_chan_pkg

`default_nettype wire

// File: rtl/argo_chan_recv.sv
// ============================================================================
// Module   : argo_chan_recv
// Purpose  : Receive-side endpoint of an Argo channel. Converts a thread's
//            blocking / non-blocking receive request into exactly one FIFO
//            pop, absorbs the FIFO RAM read latency and returns the word with
//            a one-cycle completion pulse. Keeps debug counters of stalled
//            cycles and completed receives.
// Ports    : clk, rst (async, active high)
//            recv_req/recv_nb        - thread request, non-blocking qualifier
//            recv_done/recv_ok/recv_data - completion pulse, status, word
//            busy                    - FSM not idle
//            fifo_empty/fifo_rd_en/fifo_rd_data - FIFO pop interface
//            stall_cycles/recv_count - debug counters
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module argo_chan_recv
    import argo_chan_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int RD_LATENCY  = 1,
    parameter int CHAN_ID     = 7,
    parameter int STALL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   recv_req,
    input  logic                   recv_nb,
    output logic                   recv_done,
    output logic                   recv_ok,
    output logic [DATA_WIDTH-1:0]  recv_data,
    output logic                   busy,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    output logic [STALL_WIDTH-1:0] stall_cycles,
    output logic [31:0]            recv_count
);

    // Latency-counter value on the cycle the FIFO data is valid
    localparam logic [LAT_CNT_W-1:0] c_lat_final = LAT_CNT_W'(RD_LATENCY);
    // With zero latency the data is valid in the pop cycle itself
    localparam logic                 c_lat_zero  = (RD_LATENCY == 0);

    chan_state_t            r_state;
    chan_state_t            w_next_state;
    logic [LAT_CNT_W-1:0]   r_lat;
    logic [DATA_WIDTH-1:0]  r_data;
    logic                   r_ok;
    logic [STALL_WIDTH-1:0] r_stall;
    logic [31:0]            r_count;

    logic w_idle;
    logic w_block;
    logic w_fetch;
    logic w_done;
    logic w_pop;
    logic w_fetch_last;
    logic w_capture;
    logic w_nb_miss;
    logic w_cancel;

    assign w_idle  = (r_state == CHAN_IDLE);
    assign w_block = (r_state == CHAN_BLOCK);
    assign w_fetch = (r_state == CHAN_FETCH);
    assign w_done  = (r_state == CHAN_DONE);

    // A pop is only ever issued from IDLE or BLOCK with data available; the
    // reset term keeps the strobe low while reset is held.
    assign w_pop        = ~rst & recv_req & ~fifo_empty & (w_idle | w_block);
    assign w_fetch_last = w_fetch & (r_lat == c_lat_final);
    assign w_capture    = (c_lat_zero & w_pop) | w_fetch_last;
    assign w_nb_miss    = w_idle & recv_req & fifo_empty & recv_nb;
    assign w_cancel     = w_block & ~recv_req;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CHAN_IDLE: begin
                if (recv_req) begin
                    if (!fifo_empty)
                        w_next_state = c_lat_zero ? CHAN_DONE : CHAN_FETCH;
                    else if (recv_nb)
                        w_next_state = CHAN_DONE;
                    else
                        w_next_state = CHAN_BLOCK;
                end
            end
            CHAN_BLOCK: begin
                if (!recv_req)
                    w_next_state = CHAN_IDLE;
                else if (!fifo_empty)
                    w_next_state = c_lat_zero ? CHAN_DONE : CHAN_FETCH;
            end
            // Pop already committed: request drops and FIFO status are ignored
            CHAN_FETCH: begin
                if (w_fetch_last)
                    w_next_state = CHAN_DONE;
            end
            default: begin
                w_next_state = CHAN_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CHAN_IDLE;
            r_lat   <= '0;
            r_data  <= '0;
            r_ok    <= 1'b0;
            r_stall <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;

            // First FETCH cycle is latency cycle 1
            if (w_pop)
                r_lat <= LAT_CNT_W'(1);
            else if (w_fetch)
                r_lat <= r_lat + LAT_CNT_W'(1);

            if (w_capture) begin
                r_data  <= fifo_rd_data;
                r_ok    <= 1'b1;
                r_count <= r_count + 32'd1;
            end else if (w_nb_miss) begin
                r_ok    <= 1'b0;
            end

            // Every cycle spent in BLOCK counts, including the wake and
            // cancel cycles; the counter sticks at all-ones.
            if (w_block && (r_stall != {STALL_WIDTH{1'b1}}))
                r_stall <= r_stall + STALL_WIDTH'(1);
        end
    end

    assign recv_done    = w_done;
    assign recv_ok      = w_done & r_ok;
    assign recv_data    = r_data;
    assign busy         = ~w_idle;
    assign fifo_rd_en   = w_pop;
    assign stall_cycles = r_stall;
    assign recv_count   = r_count;

`ifndef SYNTHESIS
    // Debug trace and pop-while-empty check (simulation only)
    logic [31:0] r_dbg_cyc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_dbg_cyc <= '0;
        else
            r_dbg_cyc <= r_dbg_cyc + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(fifo_rd_en && fifo_empty))
                else $error("%s ch%0d: pop issued while FIFO empty", TRACE_TAG_RECV, CHAN_ID);
            if (w_idle && recv_req)
                $display("[%s ch%0d @%0d] %s", TRACE_TAG_RECV, CHAN_ID, r_dbg_cyc, TRACE_EV_ACCEPT);
            if (w_idle && w_next_state == CHAN_BLOCK)
                $display("[%s ch%0d @%0d] %s", TRACE_TAG_RECV, CHAN_ID, r_dbg_cyc, TRACE_EV_BLOCK);
            if (w_block && w_pop)
                $display("[%s ch%0d @%0d] %s", TRACE_TAG_RECV, CHAN_ID, r_dbg_cyc, TRACE_EV_WAKE);
            if (w_cancel)
                $display("[%s ch%0d @%0d] %s", TRACE_TAG_RECV, CHAN_ID, r_dbg_cyc, TRACE_EV_CANCEL);
            if (w_done)
                $display("[%s ch%0d @%0d] %s ok=%0d data=%0h", TRACE_TAG_RECV, CHAN_ID, r_dbg_cyc,
                         TRACE_EV_DONE, recv_ok, recv_data);
        end
    end
`endif

endmodule : argo_chan_recv

`default_nettype wire

// File: tb/tb_argo_chan_recv.sv
// ============================================================================
// Module   : tb_argo_chan_recv
// Purpose  : Self-checking bench for argo_chan_recv. Four instances, one per
//            read latency 0..3 (lane index == latency), each fed by a small
//            FIFO model with the matching read pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_argo_chan_recv;

    logic        clk;
    logic        rst;

    logic        req     [4];
    logic        nb      [4];
    logic        done    [4];
    logic        ok      [4];
    logic [31:0] data    [4];
    logic        busy    [4];
    logic        empty   [4];
    logic        rd_en   [4];
    logic [31:0] rd_data [4];
    logic [15:0] stall   [4];
    logic [31:0] count   [4];

    // FIFO model storage and write pointers, written only by the stimulus
    logic [31:0] mem [4][32];
    logic [4:0]  wp  [4];

    int n_tests;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [4:0]  rp;
        logic [31:0] sr0, sr1, sr2;

        always @(posedge clk) begin
            if (rst)
                rp <= '0;
            else if (rd_en[i])
                rp <= rp + 5'd1;
            // Read pipeline: sr(k) holds the head word popped k+1 cycles ago
            sr0 <= mem[i][rp];
            sr1 <= sr0;
            sr2 <= sr1;
        end

        assign empty[i] = (wp[i] == rp);

        if (i == 0) begin : g_rd0
            assign rd_data[i] = mem[i][rp];
        end else if (i == 1) begin : g_rd1
            assign rd_data[i] = sr0;
        end else if (i == 2) begin : g_rd2
            assign rd_data[i] = sr1;
        end else begin : g_rd3
            assign rd_data[i] = sr2;
        end

        argo_chan_recv #(
            .DATA_WIDTH  (32),
            .RD_LATENCY  (i),
            .CHAN_ID     (i),
            .STALL_WIDTH (16)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .recv_req     (req[i]),
            .recv_nb      (nb[i]),
            .recv_done    (done[i]),
            .recv_ok      (ok[i]),
            .recv_data    (data[i]),
            .busy         (busy[i]),
            .fifo_empty   (empty[i]),
            .fifo_rd_en   (rd_en[i]),
            .fifo_rd_data (rd_data[i]),
            .stall_cycles (stall[i]),
            .recv_count   (count[i])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
            else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    task automatic push(input int l, input logic [31:0] v);
        mem[l][wp[l]] = v;
        wp[l] = wp[l] + 5'd1;
    endtask

    initial begin
        int got;
        int last;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        for (int l = 0; l < 4; l++) begin
            req[l] = 1'b0;
            nb[l]  = 1'b0;
            wp[l]  = '0;
        end

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        chk("rst_done",  {31'd0, done[1]}, 32'd0);
        chk("rst_ok",    {31'd0, ok[1]},   32'd0);
        chk("rst_data",  data[1],          32'd0);
        chk("rst_busy",  {31'd0, busy[1]}, 32'd0);
        chk("rst_stall", {16'd0, stall[1]}, 32'd0);
        chk("rst_count", count[1],         32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ---------------- blocking receive, non-empty (L=1) ----------------
        push(1, 32'hDEADBEEF);
        req[1] = 1'b1;                                  // cycle T
        #1 chk("t1_rden_T", {31'd0, rd_en[1]}, 32'd1);
        @(negedge clk);                                 // T+1: FETCH
        chk("t1_rden_T1", {31'd0, rd_en[1]}, 32'd0);
        chk("t1_done_T1", {31'd0, done[1]},  32'd0);
        chk("t1_busy_T1", {31'd0, busy[1]},  32'd1);
        @(negedge clk);                                 // T+2: DONE
        chk("t1_done", {31'd0, done[1]}, 32'd1);
        chk("t1_ok",   {31'd0, ok[1]},   32'd1);
        chk("t1_data", data[1],          32'hDEADBEEF);
        chk("t1_count", count[1],        32'd1);
        req[1] = 1'b0;
        @(negedge clk);
        chk("t1_done_after", {31'd0, done[1]}, 32'd0);
        chk("t1_busy_after", {31'd0, busy[1]}, 32'd0);

        // ---------------- block then wake (L=1) ----------------
        req[1] = 1'b1;                                  // cycle 3: go to BLOCK
        repeat (6) begin                                // cycles 4..9 in BLOCK
            @(negedge clk);
            chk("t2_block_rden", {31'd0, rd_en[1]}, 32'd0);
        end
        @(negedge clk);                                 // cycle 10: data arrives
        push(1, 32'h0000_1234);
        #1 chk("t2_wake_rden", {31'd0, rd_en[1]}, 32'd1);
        @(negedge clk);                                 // cycle 11
        chk("t2_stall", {16'd0, stall[1]}, 32'd7);
        chk("t2_done_11", {31'd0, done[1]}, 32'd0);
        @(negedge clk);                                 // cycle 12
        chk("t2_done", {31'd0, done[1]}, 32'd1);
        chk("t2_data", data[1],          32'h0000_1234);
        chk("t2_count", count[1],        32'd2);
        req[1] = 1'b0;
        @(negedge clk);

        // ---------------- non-blocking miss (L=1) ----------------
        req[1] = 1'b1;
        nb[1]  = 1'b1;
        #1 chk("t3_rden", {31'd0, rd_en[1]}, 32'd0);
        @(negedge clk);
        chk("t3_done",  {31'd0, done[1]}, 32'd1);
        chk("t3_ok",    {31'd0, ok[1]},   32'd0);
        chk("t3_data",  data[1],          32'h0000_1234);
        chk("t3_count", count[1],         32'd2);
        req[1] = 1'b0;
        nb[1]  = 1'b0;
        @(negedge clk);
        chk("t3_busy_after", {31'd0, busy[1]}, 32'd0);

        // ---------------- cancel (L=0 instance, fresh counters) ----------------
        req[0] = 1'b1;                                  // T: to BLOCK
        for (int c = 1; c <= 4; c++) begin              // BLOCK cycles T+1..T+4
            @(negedge clk);
            chk("t4_done", {31'd0, done[0]}, 32'd0);
            chk("t4_busy", {31'd0, busy[0]}, 32'd1);
            if (c == 4) req[0] = 1'b0;
            #1 chk("t4_rden", {31'd0, rd_en[0]}, 32'd0);
        end
        @(negedge clk);
        chk("t4_idle",  {31'd0, busy[0]}, 32'd0);
        chk("t4_done_after", {31'd0, done[0]}, 32'd0);
        chk("t4_stall", {16'd0, stall[0]}, 32'd4);
        chk("t4_count", count[0], 32'd0);

        // ---------------- latency sweep and streaming ----------------
        for (int l = 0; l < 4; l++) begin
            if (l != 1) begin
                for (int k = 1; k <= 8; k++) push(l, 32'(k));
                req[l] = 1'b1;
                got  = 0;
                last = 0;
                for (int c = 0; c < 200 && got < 8; c++) begin
                    @(negedge clk);
                    if (rd_en[l] && empty[l])
                        chk("t5_pop_empty", {31'd0, rd_en[l]}, 32'd0);
                    if (done[l]) begin
                        got++;
                        chk("t5_ok",   {31'd0, ok[l]}, 32'd1);
                        chk("t5_data", data[l], 32'(got));
                        if (got > 1) chk("t5_spacing", 32'(c - last), 32'(l + 2));
                        last = c;
                        if (got == 8) req[l] = 1'b0;
                    end
                end
                chk("t5_budget", 32'(got), 32'd8);
                @(negedge clk);
                chk("t5_count", count[l], 32'd8);
                chk("t5_idle",  {31'd0, busy[l]}, 32'd0);
            end
        end

        // ---------------- reset mid-FETCH (L=3) ----------------
        push(3, 32'h0000_0055);
        push(3, 32'h0000_0066);
        req[3] = 1'b1;                                  // pop at T
        #1 chk("t6_pop", {31'd0, rd_en[3]}, 32'd1);
        @(negedge clk);                                 // T+1
        @(negedge clk);                                 // T+2
        #2 rst = 1'b1;
        #1;
        chk("t6_busy",  {31'd0, busy[3]},  32'd0);
        chk("t6_done",  {31'd0, done[3]},  32'd0);
        chk("t6_ok",    {31'd0, ok[3]},    32'd0);
        chk("t6_data",  data[3],           32'd0);
        chk("t6_count", count[3],          32'd0);
        chk("t6_rden",  {31'd0, rd_en[3]}, 32'd0);
        chk("t6_stall0", {16'd0, stall[0]}, 32'd0);
        chk("t6_count1", count[1],          32'd0);
        @(negedge clk);
        for (int l = 0; l < 4; l++) wp[l] = '0;
        req[3] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t6_no_done", {31'd0, done[3]}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_argo_chan_recv

`default_nettype wire

// File: doc/argo_chan_recv.md
# argo_chan_recv

Receive-side endpoint for an Argo channel, sitting between a compiled thread's control FSM and the channel FIFO (`argo_fifo`). It turns the thread's receive request (blocking or non-blocking, as in `select` with `default`) into exactly one FIFO pop. It absorbs the FIFO RAM's read latency and returns the received word with a one-cycle completion pulse. It also keeps per-channel debug counters of stalled cycles and completed receives.

## Interface
- `DATA_WIDTH`, 32: channel element width; must match the FIFO.
- `RD_LATENCY`, 1: cycles from `fifo_rd_en` high to valid `fifo_rd_data`. Legal values are 0 to 3.
- `CHAN_ID`, 7: channel ID used in `$display` trace lines.
- `STALL_WIDTH`, 16: width of the stall counter.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `recv_req`  in  1  thread requests a receive; held high until `recv_done`.
- `recv_nb`  in  1  non-blocking qualifier; sampled only with `recv_req` in IDLE.
- `recv_done`  out  1  one-cycle completion pulse.
- `recv_ok`  out  1  valid with `recv_done`; 1 = word received, 0 = non-blocking miss.
- `recv_data`  out  DATA_WIDTH  received word; holds its value until the next successful receive.
- `busy`  out  1  high whenever the state is not IDLE.
- `fifo_empty`  in  1  FIFO empty status.
- `fifo_rd_en`  out  1  pop strobe to the FIFO; combinational from state and inputs.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO read data.
- `stall_cycles`  out  STALL_WIDTH  cumulative count of cycles spent in BLOCK; saturates at all-ones.
- `recv_count`  out  32  count of successful receives; wraps.

## Operation
States are IDLE, BLOCK, FETCH and DONE.
- **IDLE:**
  - `recv_req` and not `fifo_empty`: `fifo_rd_en`=1 this cycle. Go to FETCH, or to DONE with capture if `RD_LATENCY`=0.
  - `recv_req`, `fifo_empty` and `recv_nb`: go to DONE with `recv_ok`=0. No pop.
  - `recv_req`, `fifo_empty`, `recv_nb` low: go to BLOCK.
- **BLOCK:**
  - `recv_req` low: cancel and return to IDLE. No pop, no `recv_done`.
  - `fifo_empty` low: `fifo_rd_en`=1, then proceed as from IDLE.
  - Otherwise stay, and increment `stall_cycles` (saturating).
- **FETCH:**
  - A latency counter counts to `RD_LATENCY`.
  - On the final cycle, capture `fifo_rd_data` into `recv_data` and go to DONE.
  - Once FETCH is entered the pop is committed; `recv_req` dropping is ignored.
- **DONE:**
  - `recv_done`=1 for exactly one cycle, with `recv_ok` set as above. Then return to IDLE.
  - On a successful receive, `recv_count` increments on entry to DONE.
  - A request is never accepted in the DONE cycle.
- **Invariants:**
  - `fifo_rd_en` is never high while `fifo_empty`=1; checked by a simulation assertion.
  - Exactly one `fifo_rd_en` cycle per successful receive.

## Timing
- **Reset values:** state=IDLE, `recv_done`=0, `recv_ok`=0, `recv_data`=0, `busy`=0, `stall_cycles`=0, `recv_count`=0. `fifo_rd_en` is low throughout reset.
- **Latency:** if the pop is issued in cycle T, the data is captured at the end of cycle T+`RD_LATENCY` and `recv_done`/`recv_data` are valid in cycle T+`RD_LATENCY`+1.
- **Throughput:** back-to-back successful receives run at one per `RD_LATENCY`+2 cycles.
- **Non-blocking miss:** request in cycle T gives `recv_done` in T+1 with `recv_ok`=0.
- **Wake-up from BLOCK:** if `fifo_empty` falls in cycle T, `fifo_rd_en` is high in T.
- **Reset mid-operation:** state returns to IDLE immediately. An entry popped but not yet captured is discarded; the FIFO is reset in the same domain. All counters clear.
- **FIFO status during FETCH:** `fifo_empty` transitions are ignored.

## Structure
- Shared package `argo_chan_pkg` holds:
  - state encodings (`CHAN_IDLE`, `CHAN_BLOCK`, `CHAN_FETCH`, `CHAN_DONE`);
  - the `RD_LATENCY` legal-range constant;
  - the debug-trace format constants.

  The future `argo_chan_send` uses the same package.
- No sub-module: one FSM plus the latency counter, capture register and two debug counters.
- Trace with `$display` on accept, block, wake, cancel and done, tagged with `CHAN_ID` and a local cycle counter.

## Test plan
- **Blocking receive, non-empty.** `RD_LATENCY`=1, FIFO holds 0xDEADBEEF; `recv_req` in cycle 5. Expect `fifo_rd_en` in cycle 5 only, `recv_done`/`recv_ok`=1 in cycle 7, `recv_data`=0xDEADBEEF, `recv_count`=1.
- **Block then wake.** Empty FIFO, `recv_req` at cycle 3; a write makes `fifo_empty`=0 at cycle 10. Expect `stall_cycles`=7, `fifo_rd_en` at cycle 10, `recv_done` at cycle 12.
- **Non-blocking miss.** Empty FIFO, `recv_req`+`recv_nb` at cycle 4. Expect `recv_done` in cycle 5 with `recv_ok`=0, `recv_data` unchanged, no `fifo_rd_en`, `recv_count` unchanged.
- **Cancel.** Block for 4 cycles, drop `recv_req`. Expect a return to IDLE, no `recv_done`, no pop, `stall_cycles`=4.
- **Latency sweep and streaming.** For `RD_LATENCY` of 0, 2 and 3, receive 8 items 1..8 with `recv_req` held continuously. Expect the data in order, done spacing of `RD_LATENCY`+2 cycles, and `fifo_rd_en` never asserted while empty.
- **Reset mid-FETCH.** `RD_LATENCY`=3, assert `rst` asynchronously two cycles after the pop. Expect all outputs at their reset values immediately and no `recv_done`.
